// File: rtl/chua_key_extractor.sv
// Drives the held Chua state into the step datapath, skips WARMUP iterations, then packs mantissa-LSB chunks into a key.
// Latency: start-accept edge to key_valid = 1 + (W + KEY_W/BITS_PER_STEP)*(STEP_LAT+1) cycles.
// Backpressure: key held in HOLD until key_valid && key_ready; start ignored outside IDLE. Optional macro DEGEN_CHECK_EN.
module chua_key_extractor #(
    parameter int KEY_W         = 128,
    parameter int BITS_PER_STEP = 8,
    parameter int WARMUP        = 1000,
    parameter int STEP_LAT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reseed,
    input  logic [31:0]      seed_x,
    input  logic [31:0]      seed_y,
    input  logic [31:0]      seed_z,
    output logic [31:0]      step_hx,
    output logic [31:0]      step_hy,
    output logic [31:0]      step_hz,
    input  logic [31:0]      step_x,
    input  logic [31:0]      step_y,
    input  logic [31:0]      step_z,
    output logic             busy,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             err
);
    localparam int B   = BITS_PER_STEP;
    localparam int NCH = KEY_W / B;
    localparam int LW  = (STEP_LAT > 0) ? $clog2(STEP_LAT + 1) : 1;
    localparam int CW  = $clog2(NCH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WARM, EXTRACT, HOLD} state_t;

    state_t           state, next_state;
    logic [LW-1:0]    lat_cnt;
    logic [15:0]      iter_cnt;
    logic [CW-1:0]    chunk_cnt;
    logic [31:0]      seed_xq, seed_yq, seed_zq;
    logic             reseed_q;
    logic [KEY_W-1:0] key_sh, key_next;
    logic [B-1:0]     chunk;
    logic             capture, last_chunk, degen;

`ifdef DEGEN_CHECK_EN
    logic err_q;

    function automatic logic is_degen(input logic [31:0] v);
        return (v[30:23] == 8'h00) || (v[30:23] == 8'hFF);
    endfunction

    assign degen = is_degen(step_x) || is_degen(step_y) || is_degen(step_z);
    assign err   = err_q;
`else
    assign degen = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        chunk      = step_x[B-1:0] ^ step_y[B-1:0] ^ step_z[B-1:0];
        key_next   = KEY_W'({key_sh, chunk});
        capture    = ((state == WARM) || (state == EXTRACT)) && (lat_cnt == LW'(STEP_LAT));
        last_chunk = (chunk_cnt == CW'(NCH - 1));
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = (reseed_q && (WARMUP != 0)) ? WARM : EXTRACT;
            WARM: begin
                if (capture) begin
                    if (degen)                  next_state = IDLE;
                    else if (iter_cnt == 16'd1) next_state = EXTRACT;
                end
            end
            EXTRACT: begin
                if (capture) begin
                    if (degen)           next_state = IDLE;
                    else if (last_chunk) next_state = HOLD;
                end
            end
            HOLD:    if (key_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            iter_cnt  <= '0;
            chunk_cnt <= '0;
            seed_xq   <= '0;
            seed_yq   <= '0;
            seed_zq   <= '0;
            reseed_q  <= 1'b0;
            key_sh    <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            step_hx   <= '0;
            step_hy   <= '0;
            step_hz   <= '0;
`ifdef DEGEN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        reseed_q <= reseed;
                        seed_xq  <= seed_x;
                        seed_yq  <= seed_y;
                        seed_zq  <= seed_z;
`ifdef DEGEN_CHECK_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    lat_cnt   <= '0;
                    chunk_cnt <= '0;
                    if (reseed_q) begin
                        step_hx  <= seed_xq;
                        step_hy  <= seed_yq;
                        step_hz  <= seed_zq;
                        iter_cnt <= 16'(WARMUP);
                    end else begin
                        iter_cnt <= '0;
                    end
                end
                WARM, EXTRACT: begin
                    lat_cnt <= capture ? '0 : lat_cnt + 1'b1;
                    if (capture) begin
                        // A degenerate capture aborts without disturbing the held state.
                        if (degen) begin
                            busy <= 1'b0;
`ifdef DEGEN_CHECK_EN
                            err_q <= 1'b1;
`endif
                        end else begin
                            step_hx <= step_x;
                            step_hy <= step_y;
                            step_hz <= step_z;
                            if (state == WARM) begin
                                iter_cnt <= iter_cnt - 16'd1;
                            end else begin
                                key_sh    <= key_next;
                                chunk_cnt <= chunk_cnt + 1'b1;
                                if (last_chunk) begin
                                    key_out   <= key_next;
                                    key_valid <= 1'b1;
                                    busy      <= 1'b0;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (key_ready) key_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
